// File: rtl/cdf_lut_birimi_pkg.sv
// rtl/cdf_lut_birimi_pkg.sv - shared widths, defaults and FSM states for the CDF/LUT builder
package cdf_lut_birimi_pkg;

    localparam int PIXEL_BIT                = 8;
    localparam int LUT_BIT                  = 8;
    localparam int VARSAYILAN_PIXEL_SAYISI  = 76800;
    localparam int VARSAYILAN_SAYAC_BIT     = 17;

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        OKU   = 3'd1,
        BEKLE = 3'd2,
        BOL   = 3'd3,
        YAZ   = 3'd4,
        BITTI = 3'd5
    } durum_t;

endpackage

// File: rtl/cdf_lut_birimi_bolucu_8.sv
// rtl/cdf_lut_birimi_bolucu_8.sv - fixed 8-cycle restoring divider producing an 8-bit quotient
module bolucu_8 #(
    parameter int BOLUNEN_BIT = 25,
    parameter int BOLEN_BIT   = 17
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   yukle_i,
    input  logic                   adim_i,
    input  logic [BOLUNEN_BIT-1:0] bolunen_i,
    input  logic [BOLEN_BIT-1:0]   bolen_i,
    output logic [7:0]             bolum_o,
    output logic                   tasma_o
);

    localparam int GENIS = (BOLUNEN_BIT > BOLEN_BIT + 8) ? BOLUNEN_BIT : BOLEN_BIT + 8;

    logic [GENIS-1:0] kalan_q, kalan_d;
    logic [GENIS-1:0] bolen_q, bolen_d;
    logic [7:0]       bolum_q, bolum_d;
    logic             tasma_q, tasma_d;

    // A zero divisor makes every step succeed, so the quotient naturally becomes 255.
    always_comb begin
        kalan_d = kalan_q;
        bolen_d = bolen_q;
        bolum_d = bolum_q;
        tasma_d = tasma_q;
        if (yukle_i) begin
            kalan_d = GENIS'(bolunen_i);
            bolen_d = GENIS'(bolen_i) << 7;
            bolum_d = '0;
            tasma_d = (GENIS'(bolunen_i) >= (GENIS'(bolen_i) << 8));
        end else if (adim_i) begin
            if (kalan_q >= bolen_q) begin
                kalan_d = kalan_q - bolen_q;
                bolum_d = {bolum_q[6:0], 1'b1};
            end else begin
                bolum_d = {bolum_q[6:0], 1'b0};
            end
            bolen_d = bolen_q >> 1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kalan_q <= '0;
            bolen_q <= '0;
            bolum_q <= '0;
            tasma_q <= 1'b0;
        end else begin
            kalan_q <= kalan_d;
            bolen_q <= bolen_d;
            bolum_q <= bolum_d;
            tasma_q <= tasma_d;
        end
    end

    assign bolum_o = bolum_q;
    assign tasma_o = tasma_q;

endmodule

// File: rtl/cdf_lut_birimi.sv
// rtl/cdf_lut_birimi.sv - walks the histogram, accumulates the CDF and writes the equalization LUT
module cdf_lut_birimi
    import cdf_lut_birimi_pkg::*;
#(
    parameter int PIXEL_SAYISI = VARSAYILAN_PIXEL_SAYISI,
    parameter int SAYAC_BIT    = VARSAYILAN_SAYAC_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baslat_i,
    input  logic [255:0]         valid_i,
    input  logic [SAYAC_BIT-1:0] cdf_min_i,
    output logic                 hist_rd_en_o,
    output logic [PIXEL_BIT-1:0] hist_addr_o,
    input  logic [SAYAC_BIT-1:0] hist_data_i,
    output logic                 lut_wr_en_o,
    output logic [PIXEL_BIT-1:0] lut_addr_o,
    output logic [LUT_BIT-1:0]   lut_data_o,
    output logic                 mesgul_o,
    output logic                 hazir_o
);

    localparam int                   PAY_BIT = SAYAC_BIT + 8;
    localparam logic [SAYAC_BIT-1:0] N       = SAYAC_BIT'(PIXEL_SAYISI);

    durum_t               durum_q, durum_d;
    logic [PIXEL_BIT-1:0] i_q, i_d;
    logic [SAYAC_BIT-1:0] cdf_q, cdf_d;
    logic [2:0]           adim_q, adim_d;
    logic                 den_sifir_q, den_sifir_d;

    logic [SAYAC_BIT-1:0] sayim, cdf_next, den, fark;
    logic [PAY_BIT-1:0]   pay, bolunen;
    logic                 bol_yukle, bol_adim;
    logic [LUT_BIT-1:0]   bolum;
    logic                 tasma;

    // Unwritten RAM entries hold garbage, so the valid mask gates what is summed.
    always_comb begin
        sayim    = valid_i[i_q] ? hist_data_i : '0;
        cdf_next = cdf_q + sayim;
        den      = N - cdf_min_i;
        fark     = cdf_next - cdf_min_i;
        pay      = (cdf_next > cdf_min_i) ? ((PAY_BIT'(fark) << 8) - PAY_BIT'(fark)) : '0;
        bolunen  = pay + PAY_BIT'(den >> 1);
    end

    bolucu_8 #(
        .BOLUNEN_BIT(PAY_BIT),
        .BOLEN_BIT  (SAYAC_BIT)
    ) u_bolucu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .yukle_i  (bol_yukle),
        .adim_i   (bol_adim),
        .bolunen_i(bolunen),
        .bolen_i  (den),
        .bolum_o  (bolum),
        .tasma_o  (tasma)
    );

    always_comb begin
        durum_d      = durum_q;
        i_d          = i_q;
        cdf_d        = cdf_q;
        adim_d       = adim_q;
        den_sifir_d  = den_sifir_q;
        bol_yukle    = 1'b0;
        bol_adim     = 1'b0;
        hist_rd_en_o = 1'b0;
        hist_addr_o  = '0;
        lut_wr_en_o  = 1'b0;
        lut_addr_o   = '0;
        lut_data_o   = '0;
        mesgul_o     = 1'b0;
        hazir_o      = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (baslat_i) begin
                    cdf_d   = '0;
                    i_d     = '0;
                    durum_d = OKU;
                end
            end
            OKU: begin
                mesgul_o     = 1'b1;
                hist_rd_en_o = 1'b1;
                hist_addr_o  = i_q;
                durum_d      = BEKLE;
            end
            BEKLE: begin
                mesgul_o    = 1'b1;
                cdf_d       = cdf_next;
                den_sifir_d = (den == '0);
                bol_yukle   = 1'b1;
                adim_d      = '0;
                durum_d     = BOL;
            end
            BOL: begin
                mesgul_o = 1'b1;
                bol_adim = 1'b1;
                adim_d   = adim_q + 3'd1;
                if (adim_q == 3'd7) begin
                    durum_d = YAZ;
                end
            end
            YAZ: begin
                mesgul_o    = 1'b1;
                lut_wr_en_o = 1'b1;
                lut_addr_o  = i_q;
                // A single-valued image has no spread to stretch; fall back to identity.
                lut_data_o  = den_sifir_q ? i_q : (tasma ? {LUT_BIT{1'b1}} : bolum);
                if (i_q == {PIXEL_BIT{1'b1}}) begin
                    durum_d = BITTI;
                end else begin
                    i_d     = i_q + 8'd1;
                    durum_d = OKU;
                end
            end
            BITTI: begin
                hazir_o = 1'b1;
                durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q     <= BOSTA;
            i_q         <= '0;
            cdf_q       <= '0;
            adim_q      <= '0;
            den_sifir_q <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            i_q         <= i_d;
            cdf_q       <= cdf_d;
            adim_q      <= adim_d;
            den_sifir_q <= den_sifir_d;
        end
    end

endmodule

// File: doc/cdf_lut_birimi.md
Name: cdf_lut_birimi

Overview:
- Sits directly downstream of the histogram unit in the histogram-equalization pipeline.
- After the histogram unit reports done, this block walks all 256 histogram bins in order and accumulates the CDF.
- For each bin v it computes the equalized mapping lut[v] = round((cdf(v) − cdf_min) · 255 / (N − cdf_min)) and writes it into the mapping LUT RAM, which the pixel-remap stage consumes.

Parameters:
- PIXEL_SAYISI, 76800: pixels per frame (N); must be < 2^17.
- SAYAC_BIT, 17: histogram count / CDF width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- baslat_i  in  1  start pulse; connect to the histogram unit's done output.
- valid_i  in  256  per-bin "histogram RAM entry written" mask.
- cdf_min_i  in  17  count of the minimum pixel value present.
- hist_rd_en_o  out  1  histogram RAM read enable, active-high.
- hist_addr_o  out  8  histogram RAM read address.
- hist_data_i  in  17  histogram RAM read data; valid exactly 1 cycle after hist_rd_en_o.
- lut_wr_en_o  out  1  LUT RAM write enable, active-high.
- lut_addr_o  out  8  LUT write address.
- lut_data_o  out  8  LUT write data.
- mesgul_o  out  1  high from the first OKU cycle through the last YAZ cycle.
- hazir_o  out  1  one-cycle pulse when the whole LUT has been written.

Behaviour:
- Reset: all outputs 0; FSM = BOSTA; bin index i = 0; cdf accumulator = 0.
- States: BOSTA, OKU, BEKLE, BOL, YAZ, BITTI.
- BOSTA: baslat_i=1 → clear cdf, set i=0, go to OKU. baslat_i in any other state is ignored.
- OKU (1 cycle): hist_rd_en_o=1, hist_addr_o=i → BEKLE.
- BEKLE (1 cycle):
  - cnt = valid_i[i] ? hist_data_i : 0. Garbage in unwritten RAM entries must never be summed.
  - cdf_next = cdf + cnt, 17-bit.
  - num = (cdf_next > cdf_min_i) ? (cdf_next − cdf_min_i)·255 : 0, 25-bit.
  - den = PIXEL_SAYISI − cdf_min_i, 17-bit.
  - Load divider with dividend num + (den >> 1) and divisor den → BOL.
- BOL (exactly 8 cycles): 8-iteration restoring division producing an 8-bit quotient → YAZ. Timing is fixed regardless of operands.
- YAZ (1 cycle): lut_wr_en_o=1, lut_addr_o=i, lut_data_o selected as:
  - den==0 (single-valued image) → i (identity);
  - else if quotient overflowed 8 bits → 255;
  - else quotient.
  - Then: i==255 → BITTI; else i++ → OKU.
- BITTI (1 cycle): hazir_o=1 → BOSTA.
- Per-bin cost is 11 cycles. With baslat_i sampled at cycle 0:
  - bin k is written at cycle 11 + 11k;
  - hazir_o is high at cycle 2817.
- i never wraps past 255; the cdf accumulator cannot overflow when the histogram sums to N.
- rst_i mid-operation: immediate return to BOSTA with all outputs 0. A partially written LUT is not cleared; a new baslat_i rewrites all 256 entries.
- Write enables are never asserted outside OKU and YAZ. Histogram read and LUT write are never asserted in the same cycle.

Decomposition:
- Into sabitler.vh: PIXEL_BIT (8), PIXEL_SAYISI, SAYAC_BIT, FSM state encodings, LUT_BIT (8).
- One sub-module, bolucu_8: sequential restoring divider with 25-bit dividend and 17-bit divisor.
  - Divisor pre-shifted left by 7; compare/subtract one quotient bit per cycle, MSB first.
  - 8 cycles per division; divisor 0 returns quotient 255.
  - Overflow flag when dividend ≥ divisor·256.
- The FSM, cdf accumulator and numerator multiply-by-255 (implemented as (x<<8) − x) stay in cdf_lut_birimi.

Test Plan:
- Uniform image: every bin count 300, all valid, cdf_min=300, N=76800 → lut[v]=v for all v; hazir_o pulses exactly 2817 cycles after baslat_i.
- Constant image: hist[100]=76800, only bin 100 valid, cdf_min=76800 → den=0 → lut[v]=v for all v; no X on lut_data_o.
- Two-level image: hist[0]=hist[255]=38400, cdf_min=38400 → lut[0..254]=0, lut[255]=255.
- Rounding with PIXEL_SAYISI=4: hist[0]=1, hist[1]=1, hist[2]=2, cdf_min=1 → lut[0]=0, lut[1]=85, lut[2..255]=255.
- Valid mask: same stimulus as the rounding case, but bin 50 has valid_i=0 while the RAM holds 0x1FFFF → results identical to the rounding case.
- Reset and re-start:
  - assert rst_i at cycle 500 → all outputs 0 in the same cycle, mesgul_o=0;
  - re-issue baslat_i → complete correct LUT;
  - a second baslat_i sent while mesgul_o=1 → ignored, no change in write sequence.
